// File: rtl/filtro_pkg.sv
// Shared constants, coefficient table and FSM encoding for the 8-tap
// decimating FIR filter.
package filtro_pkg;

  localparam int NTAPS        = 8;
  localparam int COEF_WIDTH   = 6;
  localparam int ROUND_SHIFT  = 6;
  localparam int ROUND_OFFSET = 32;

  typedef logic signed [COEF_WIDTH-1:0] coef_t;

  // Symmetric low-pass kernel, DC gain 64 (undone by the final >>> 6).
  localparam coef_t COEFS [NTAPS] = '{
    -6'sd2, 6'sd2, 6'sd14, 6'sd18, 6'sd18, 6'sd14, 6'sd2, -6'sd2
  };

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MAC     = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  function automatic coef_t coef_at(input logic [2:0] idx);
    return COEFS[idx];
  endfunction

endpackage

// File: rtl/filtro_mac.sv
// Registered signed multiply-accumulate with synchronous clear and advance
// enable; the product is sign-extended to the accumulator width.
module filtro_mac #(
  parameter int A_WIDTH   = 10,
  parameter int B_WIDTH   = 6,
  parameter int ACC_WIDTH = 19
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        enable,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  localparam int PW = A_WIDTH + B_WIDTH;

  logic signed [PW-1:0]        product;
  logic signed [ACC_WIDTH-1:0] product_ext;

  assign product     = a * b;
  assign product_ext = {{(ACC_WIDTH-PW){product[PW-1]}}, product};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + product_ext;
    end
  end

endmodule

// File: rtl/filtro_decimador.sv
// 8-tap FIR decimator: collects DECIM samples, runs a sequential 8-cycle MAC,
// then presents one rounded output sample through a valid/ready handshake.
module filtro_decimador
  import filtro_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DECIM      = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH+1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH+2:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output state_e                       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid, ready and
  // enable are all high; valid never waits on ready, data is held until taken.

  localparam int IN_W  = DATA_WIDTH + 2;
  localparam int OUT_W = DATA_WIDTH + 3;
  localparam int ACC_W = DATA_WIDTH + 2 + COEF_WIDTH + 3;

  localparam logic [3:0]              LAST_PHASE = 4'(DECIM - 1);
  localparam logic [3:0]              TAP_DONE   = 4'(NTAPS);
  localparam logic signed [ACC_W-1:0] RND        = ACC_W'(ROUND_OFFSET);

  state_e                  state, state_next;
  logic [3:0]              phase;
  logic [3:0]              tap;
  logic signed [IN_W-1:0]  x [NTAPS];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rounded;
  logic                    accept;
  logic                    mac_clear;
  logic                    mac_en;

  assign in_ready  = reset & enable & (state == COLLECT);
  assign accept    = in_valid & in_ready;
  assign busy      = (state != COLLECT);
  assign dbg_state = state;
  assign rounded   = (acc + RND) >>> ROUND_SHIFT;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mac_clear  = 1'b0;
    mac_en     = 1'b0;
    case (state)
      COLLECT: begin
        if (accept && phase == LAST_PHASE) begin
          state_next = MAC;
          mac_clear  = 1'b1;
        end
      end
      MAC: begin
        // tap 0..7 accumulate; tap 8 is the extra edge that rounds the sum
        if (enable) begin
          if (tap == TAP_DONE) begin
            state_next = OUTPUT;
          end else begin
            mac_en = 1'b1;
          end
        end
      end
      OUTPUT: begin
        if (out_valid && out_ready && enable) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x         <= '{default: '0};
      phase     <= '0;
      tap       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (enable) begin
      if (accept) begin
        for (int k = NTAPS - 1; k > 0; k--) begin
          x[k] <= x[k-1];
        end
        x[0] <= in_data;
        if (phase == LAST_PHASE) begin
          phase <= '0;
          tap   <= '0;
        end else begin
          phase <= phase + 4'd1;
        end
      end
      if (state == MAC) begin
        if (tap == TAP_DONE) begin
          out_data  <= OUT_W'(rounded);
          out_valid <= 1'b1;
        end else begin
          tap <= tap + 4'd1;
        end
      end
      if (state == OUTPUT && out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  filtro_mac #(
    .A_WIDTH  (IN_W),
    .B_WIDTH  (COEF_WIDTH),
    .ACC_WIDTH(ACC_W)
  ) u_mac (
    .clock (clock),
    .reset (reset),
    .clear (mac_clear),
    .enable(mac_en),
    .a     (x[tap[2:0]]),
    .b     (coef_at(tap[2:0])),
    .acc   (acc)
  );

endmodule

// File: tb/tb_filtro_decimador.sv
// Directed bench for filtro_decimador: a driver feeds sample pairs and queues
// hand-computed outputs; a negedge monitor pops and checks every output.
module tb_filtro_decimador;
  import filtro_pkg::*;

  localparam int DATA_WIDTH = 8;
  localparam int DECIM      = 2;
  localparam int IN_W       = DATA_WIDTH + 2;
  localparam int OUT_W      = DATA_WIDTH + 3;

  // ---------------- clock / reset / DUT ----------------
  logic                    clock     = 1'b0;
  logic                    reset     = 1'b0;
  logic                    enable    = 1'b1;
  logic signed [IN_W-1:0]  in_data   = '0;
  logic                    in_valid  = 1'b0;
  logic                    out_ready = 1'b1;
  logic                    in_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    busy;
  state_e                  dbg_state;

  always #5 clock = ~clock;

  filtro_decimador #(.DATA_WIDTH(DATA_WIDTH), .DECIM(DECIM)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [OUT_W-1:0] exp_q[$];
  int               n_vec     = 0;
  int               n_fail    = 0;
  int               exp_stall = 0;

  int               phase_m   = 0;
  int               raw_cnt   = 0;
  int               en_cnt    = 0;
  bit               pending   = 0;
  bit               in_mac    = 0;
  bit               lat_on    = 0;
  bit               hold_v    = 0;
  bit               last_en   = 1;
  logic [OUT_W-1:0] hold_d    = '0;

  // Hand-computed vectors (x[0] newest, h = -2 2 14 18 18 14 2 -2, round half up).
  int imp_in  [10] = '{100, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int imp_exp [5]  = '{3, 28, 22, -3, 0};
  int dcp_exp [8]  = '{0, 50, 100, 100, 100, 100, 100, 100};
  int dcn_exp [8]  = '{100, 0, -100, -100, -100, -100, -100, -100};

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [OUT_W-1:0] exp_v;
    if (!reset) begin
      phase_m = 0;
      pending = 0;
      in_mac  = 0;
      lat_on  = 0;
      hold_v  = 0;
    end else begin
      if (lat_on) begin
        raw_cnt++;
        if (last_en) en_cnt++;
      end
      if (pending) begin
        pending = 0;
        in_mac  = 1;
        lat_on  = 1;
        raw_cnt = 0;
        en_cnt  = 0;
      end
      if (out_valid && lat_on) begin
        check("latency_enabled_edges", en_cnt, 9);
        check("latency_raw_edges", raw_cnt, 9 + exp_stall);
        lat_on = 0;
        in_mac = 0;
      end
      if (hold_v) begin
        check("hold_out_valid", int'(out_valid), 1);
        check("hold_out_data", int'(out_data), int'($signed(hold_d)));
      end
      check("busy", int'(busy), int'(in_mac || out_valid));
      check("in_ready", int'(in_ready), int'(enable && !(in_mac || out_valid)));
      hold_v = 0;
      if (out_valid && out_ready && enable) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL out_data: unexpected output %0d, expected none", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          check("out_data", int'(out_data), int'($signed(exp_v)));
        end
      end else if (out_valid) begin
        hold_v = 1;
        hold_d = out_data;
      end
      if (in_valid && in_ready && enable) begin
        phase_m++;
        if (phase_m == DECIM) begin
          phase_m = 0;
          pending = 1;
        end
      end
    end
    last_en = enable;
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input int s);
    int guard = 0;
    bit done  = 0;
    in_data  = IN_W'(s);
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clock);
      if (in_ready && enable && reset) begin
        done = 1;
      end else if (++guard > 200) begin
        n_vec++;
        n_fail++;
        $display("FAIL send_timeout: sample %0d not accepted, expected accept within 200 cycles", s);
        done = 1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic group(input int a, input int b, input int e);
    send(a);
    send(b);
    exp_q.push_back(OUT_W'(e));
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      step(1);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    step(2);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_busy", int'(busy), 0);
    exp_q.delete();
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic run_impulse();
    for (int g = 0; g < 5; g++) begin
      group(imp_in[2*g], imp_in[2*g+1], imp_exp[g]);
    end
    drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    step(3);
    do_reset();

    run_impulse();

    for (int g = 0; g < 8; g++) group(100, 100, dcp_exp[g]);
    drain();
    for (int g = 0; g < 8; g++) group(-100, -100, dcn_exp[g]);
    drain();

    // back-pressure: hold the output 5 cycles while offering a stray sample
    do_reset();
    out_ready = 1'b0;
    group(100, 0, 3);
    guard = 0;
    while (!out_valid && guard < 100) begin
      step(1);
      guard++;
    end
    check("bp_out_valid_seen", int'(out_valid), 1);
    in_data  = IN_W'(77);
    in_valid = 1'b1;
    step(5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    group(0, 0, 28);
    drain();

    // enable stall of 3 cycles at tap 4
    do_reset();
    group(100, 0, 3);
    drain();
    send(0);
    send(0);
    exp_q.push_back(OUT_W'(28));
    step(4);
    exp_stall = 3;
    enable    = 1'b0;
    step(3);
    enable    = 1'b1;
    drain();
    exp_stall = 0;

    // reset in the middle of a MAC run discards the partial result
    do_reset();
    group(100, 0, 3);
    drain();
    send(0);
    send(0);
    step(3);
    #2;
    reset = 1'b0;
    #1;
    check("midmac_out_valid", int'(out_valid), 0);
    check("midmac_out_data", int'(out_data), 0);
    check("midmac_busy", int'(busy), 0);
    check("midmac_in_ready", int'(in_ready), 0);
    exp_q.delete();
    @(posedge clock);
    #1;
    step(1);
    reset = 1'b1;
    step(1);
    run_impulse();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
